// File: rtl/ldpc_dec_pkg.sv
// Shared constants for the GF(257) 4x24 LDPC decoder: bank geometry, circulant row offsets, VPU write-back FSM states.
// The row-offset table is common to the VPU read and write address generators.
package ldpc_dec_pkg;

    localparam int NBANK = 27;
    localparam int NMAIN = 24;

    // Entries 0..23 are the main banks; 24..26 are the appendix banks.
    localparam int unsigned ROW_START [NBANK] = '{
        9, 72, 177, 47, 198, 97, 94, 212, 30, 247, 10, 189,
        126, 18, 84, 57, 70, 36, 101, 42, 246, 35, 125, 106,
        102, 112, 208
    };

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_ptr.sv
// Loadable modulo-Z address pointer: load jumps to the bank's row offset, inc steps and wraps Z-1 -> 0.
// Value updates the cycle after load/inc; no backpressure.
module wb_ptr #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          Z          = 256,
    parameter int unsigned INIT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_value
);

    localparam logic [ADDR_WIDTH-1:0] INIT_V = ADDR_WIDTH'(INIT % Z);
    // Explicit compare so a non-power-of-two Z still wraps correctly.
    localparam logic [ADDR_WIDTH-1:0] LAST_V = ADDR_WIDTH'(Z - 1);

    logic [ADDR_WIDTH-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= INIT_V;
        end else if (i_inc) begin
            r_value <= (r_value == LAST_V) ? '0 : r_value + 1'b1;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/vpu_wb_addr_gen.sv
// VPU write-back address generator: one write strobe per result beat across all 27 banks, done on the LEN-th write.
// Latency res_vld -> wr_en is 1 cycle; no backpressure, gaps in res_vld are simply held over.
module vpu_wb_addr_gen
    import ldpc_dec_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int Z          = 256,
    parameter int LEN        = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        res_vld,
    output logic                        wr_en,
    output logic [NBANK*ADDR_WIDTH-1:0] wr_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        err_unexp
);

    localparam logic [8:0] LAST_BEAT = 9'(LEN - 1);

    wb_state_t                   r_state;
    wb_state_t                   w_state_nxt;
    logic [8:0]                  r_cnt;
    logic                        w_load;
    logic                        w_beat;
    logic                        w_last;
    logic [NBANK*ADDR_WIDTH-1:0] w_ptrs;
    logic [NBANK*ADDR_WIDTH-1:0] r_wr_addr;
    logic                        r_wr_en;
    logic                        r_done;
    logic                        r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (res_vld) begin
                    w_beat = 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_wr_addr <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 9'd1;
            end
            r_wr_en <= w_beat;
            r_done  <= w_last;
            if (w_beat) begin
                r_wr_addr <= w_ptrs;
            end
            // A beat in the start cycle still counts as unexpected.
            if (r_state == ST_IDLE && res_vld) begin
                r_err <= 1'b1;
            end else if (w_load) begin
                r_err <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NBANK; k++) begin : g_bank
        wb_ptr #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .Z          (Z),
            .INIT       (ROW_START[k])
        ) u_ptr (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load),
            .i_inc   (w_beat),
            .o_value (w_ptrs[k*ADDR_WIDTH +: ADDR_WIDTH])
        );
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign busy      = (r_state == ST_WRITE);
    assign done      = r_done;
    assign err_unexp = r_err;

endmodule
